// File: rtl/gs_pkg.sv
// Shared types for the gs instruction prefetch stage: request FSM states,
// the buffered fetch entry and the default buffer depth.
package gs_pkg;

  localparam int unsigned PF_DEPTH_DEFAULT = 2;
  localparam int unsigned PF_XLEN          = 32;

  typedef enum logic [1:0] {
    INITIAL  = 2'd0,
    PENDING  = 2'd1,
    FETCHING = 2'd2
  } pf_state_t;

  typedef struct packed {
    logic [PF_XLEN-1:0] instr;
    logic [PF_XLEN-1:0] pc;
    logic               err;
  } fetch_entry_t;

endpackage

// File: rtl/gs_fifo.sv
// Synchronous FIFO of fetch entries with a single-cycle flush; head entry is
// presented combinationally on data_o.
module gs_fifo
  import gs_pkg::*;
#(
  parameter int unsigned DEPTH = PF_DEPTH_DEFAULT
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  fetch_entry_t                 data_i,
  input  logic                         pop_i,
  output fetch_entry_t                 data_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         full_o,
  output logic                         empty_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t   mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q;
  logic [AW-1:0]  rd_ptr_q;
  logic [CW-1:0]  count_q;
  logic           do_push;
  logic           do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A push on a full FIFO is accepted only when the head leaves in the same cycle.
  assign do_push = push_i & (~full_o | pop_i);
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/gs_prefetch.sv
// Instruction prefetch stage: req/gnt/rvalid fetch into a small FIFO feeding decode.
// Optional GS_PF_BYPASS_EN forwards a response straight to decode when the FIFO is empty.
module gs_prefetch
  import gs_pkg::*;
#(
  parameter int unsigned DEPTH = PF_DEPTH_DEFAULT,
  parameter int unsigned XLEN  = PF_XLEN
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            en_i,
  input  logic [XLEN-1:0] boot_addr_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] flush_addr_i,
  output logic            instr_req_o,
  output logic [XLEN-1:0] instr_addr_o,
  input  logic            instr_gnt_i,
  input  logic            instr_rvalid_i,
  input  logic [XLEN-1:0] instr_rdata_i,
  input  logic            instr_err_i,
  output logic            fetch_valid_o,
  output logic [XLEN-1:0] fetch_instr_o,
  output logic [XLEN-1:0] fetch_pc_o,
  output logic            fetch_err_o,
  input  logic            fetch_ready_i,
  output logic            busy_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  pf_state_t       state_q, state_d;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] resp_pc_q;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   discard_q, discard_d;
  logic [CW-1:0]   fifo_count, fifo_count_d;
  logic [CW:0]     occupancy_d;
  logic            fifo_full, fifo_empty;
  logic            gnt_fire, accept, bypass, push, pop, room;
  fetch_entry_t    push_entry, head_entry, out_entry;

  assign instr_req_o  = (state_q == PENDING);
  assign instr_addr_o = addr_q;
  assign gnt_fire     = instr_req_o & instr_gnt_i;

  // Responses arriving while stale requests drain, or during a flush, are dropped.
  assign accept = instr_rvalid_i & (discard_q == '0) & ~flush_i;

`ifdef GS_PF_BYPASS_EN
  assign bypass = accept & fifo_empty & fetch_ready_i;
`else
  assign bypass = 1'b0;
`endif

  assign push = accept & ~bypass & (~fifo_full | pop);
  assign pop  = ~fifo_empty & fetch_ready_i;

  assign push_entry = '{instr: instr_rdata_i, pc: resp_pc_q, err: instr_err_i};

  gs_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (pop),
    .data_o  (head_entry),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Room is judged on next-cycle occupancy so a grant never overbooks the FIFO.
  assign outstanding_d = outstanding_q + CW'(gnt_fire) - CW'(instr_rvalid_i);
  assign fifo_count_d  = flush_i ? '0 : fifo_count + CW'(push) - CW'(pop);
  assign occupancy_d   = (CW+1)'(outstanding_d) + (CW+1)'(fifo_count_d);
  assign room          = (occupancy_d < (CW+1)'(DEPTH));

  always_comb begin
    discard_d = discard_q;
    if (flush_i) begin
      discard_d = outstanding_d;
    end else if (instr_rvalid_i && (discard_q != '0)) begin
      discard_d = discard_q - CW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      INITIAL: begin
        if (en_i && room) state_d = PENDING;
      end
      PENDING: begin
        if (instr_gnt_i) begin
          if (!en_i)     state_d = INITIAL;
          else if (room) state_d = PENDING;
          else           state_d = FETCHING;
        end
      end
      FETCHING: begin
        if (!en_i)     state_d = INITIAL;
        else if (room) state_d = PENDING;
      end
      default: state_d = INITIAL;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= INITIAL;
      outstanding_q <= '0;
      discard_q     <= '0;
      addr_q        <= boot_addr_i & ~XLEN'(3);
      resp_pc_q     <= boot_addr_i & ~XLEN'(3);
    end else begin
      state_q       <= state_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      if (flush_i) begin
        addr_q    <= flush_addr_i & ~XLEN'(3);
        resp_pc_q <= flush_addr_i & ~XLEN'(3);
      end else begin
        if (gnt_fire) addr_q    <= addr_q + XLEN'(4);
        if (accept)   resp_pc_q <= resp_pc_q + XLEN'(4);
      end
    end
  end

  assign out_entry     = bypass ? push_entry : head_entry;
  assign fetch_valid_o = ~fifo_empty | bypass;
  assign fetch_instr_o = out_entry.instr;
  assign fetch_pc_o    = out_entry.pc;
  assign fetch_err_o   = fetch_valid_o & out_entry.err;
  assign busy_o        = (outstanding_q != '0) | (discard_q != '0);

endmodule

// File: doc/gs_prefetch.md
Name: gs_prefetch

Overview:
Instruction prefetch stage directly upstream of the decode stage. Issues word-aligned instruction-memory requests over a req/gnt/rvalid bus, buffers returned words with their PC in a small FIFO, and presents them to decode over a valid/ready handshake. A flush from the controller (branch/jump redirect) drops buffered and in-flight instructions and restarts fetch at a new address.

Parameters:
DEPTH, 2, FIFO entries; also the maximum outstanding requests plus buffered entries (>=1)
XLEN, 32, address and instruction width

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset
en_i  in  1  fetch enable from controller (set in BOOT_SET, held thereafter)
boot_addr_i  in  XLEN  address loaded during reset
flush_i  in  1  redirect request (PC_BRANCH/PC_JUMP taken)
flush_addr_i  in  XLEN  redirect target
instr_req_o  out  1  memory request
instr_addr_o  out  XLEN  request address, bits [1:0]=0
instr_gnt_i  in  1  request accepted
instr_rvalid_i  in  1  response valid (in request order)
instr_rdata_i  in  XLEN  response data
instr_err_i  in  1  response bus error, qualified by rvalid
fetch_valid_o  out  1  instruction available to decode
fetch_instr_o  out  XLEN  instruction
fetch_pc_o  out  XLEN  PC of instruction
fetch_err_o  out  1  fetch error for this entry (controller enters IF_ERR)
fetch_ready_i  in  1  decode accepts
busy_o  out  1  outstanding requests or discards pending

Behaviour:
- One clock; reset is synchronous and active-low (clk_i, rst_ni).
- Reset: instr_req_o=0, fetch_valid_o=0, fetch_err_o=0, fetch_instr_o=0, fetch_pc_o=0, busy_o=0; FIFO empty; outstanding=0; discard=0; state=INITIAL; fetch address register={boot_addr_i[XLEN-1:2],2'b00}; instr_addr_o reflects it.
- Request FSM (pf_state_t):
  INITIAL: req_o=0. -> PENDING when en_i=1 and room.
  PENDING: req_o=1, address stable until gnt. On gnt: addr+=4 (mod 2^XLEN, wraps 0xFFFFFFFC->0), outstanding+1; stay PENDING if en_i and room after the grant, else FETCHING (en_i=1) or INITIAL (en_i=0).
  FETCHING: req_o=0, waiting for space; -> PENDING when room; -> INITIAL if en_i=0.
- room = (outstanding + fifo_count) < DEPTH, with both counters ($clog2(DEPTH+1) bits) taking their next-cycle values.
- en_i falling while PENDING: request held until gnt (no retraction), then INITIAL.
- Response: each rvalid decrements outstanding. If discard>0: discard-1, data dropped. Else push {rdata, pc, err} into FIFO; pc comes from a response-PC register starting at the current fetch base, +4 per accepted response.
- Decode side: fetch_valid_o = FIFO non-empty; pop when valid&ready. Push and pop in the same cycle on a full FIFO are legal (room guarantees no overflow).
- Flush (highest priority): the FIFO is cleared, so fetch_valid_o=0 next cycle. discard <= outstanding after this cycle's gnt/rvalid: a gnt in the flush cycle counts as discarded; an rvalid in the flush cycle is dropped. Fetch address and response PC <= {flush_addr_i[XLEN-1:2],2'b00}. A pending un-granted request switches to the new address next cycle with req_o kept high. Flush in INITIAL only reloads the address.
- New responses are pushed only after discard reaches 0; this preserves order because responses return in order.
- busy_o = (outstanding!=0) | (discard!=0).
- Error entries are delivered like normal ones; fetch continues and the controller flushes.

Optional Feature:
GS_PF_BYPASS_EN: when defined, a non-discarded response arriving with the FIFO empty and fetch_ready_i=1 is driven combinationally to fetch_* the same cycle and not stored, giving 0-cycle latency. Without it, every response is registered and fetch_valid_o rises the cycle after rvalid.

Decomposition:
gs_pkg: existing pf_state_t (INITIAL, PENDING, FETCHING); add the fetch_entry_t packed struct {instr, pc, err} and the constant PF_DEPTH_DEFAULT=2. One sub-module, gs_fifo: a parameterised synchronous FIFO of fetch_entry_t with a flush input, count output, and full/empty flags.

Test Plan:
- Reset with boot_addr_i=0x8000_0000, en_i=1, gnt always 1, rvalid 1 cycle later: addresses 0x8000_0000, 0x8000_0004 issued; decode sees those PCs in order; with ready=0, req stops after 2 outstanding/buffered.
- gnt delayed 3 cycles: instr_addr_o held stable and req_o held high throughout; one request per grant.
- 2 outstanding, flush_i to 0x100: both responses dropped, fetch_valid_o=0 during them, first delivered PC=0x100.
- Flush in the same cycle as gnt and rvalid: discard=2 afterwards; no stale instruction is delivered.
- instr_err_i=1 on response at 0x20: entry delivered with fetch_err_o=1, pc=0x20; the next entry has err=0.
- Address 0xFFFF_FFFC, gnt: next request address is 0x0000_0000.
